// File: rtl/msx_mouse_port.sv
// msx_mouse_port: shares MSX joystick port A between a PS/2 mouse and a
// digital joystick. Mouse motion is accumulated with saturation and served
// through the 4-phase nibble protocol clocked by the PPI strobe pin.
module msx_mouse_port #(
    parameter int unsigned TIMEOUT = 100000,
    parameter int unsigned TW      = 17
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       mouse_strobe,
    input  logic [8:0] mouse_dx,
    input  logic [8:0] mouse_dy,
    input  logic [1:0] mouse_btn,
    input  logic [5:0] joy_n,
    input  logic       msx_str,
    output logic [5:0] port_data,
    output logic       mouse_active
);

    localparam int unsigned ACC_W = 8;
    localparam int unsigned SUM_W = 10;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned PD_W  = 6;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    localparam logic signed [SUM_W-1:0] SAT_MAX = 10'sd127;
    localparam logic signed [SUM_W-1:0] SAT_MIN = -10'sd128;
    localparam logic [PD_W-1:0]         JOY_IDLE = 6'h3F;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_x_q, acc_x_d;
    logic [ACC_W-1:0] acc_y_q, acc_y_d;
    logic [ACC_W-1:0] tx_x_q, tx_x_d;
    logic [ACC_W-1:0] tx_y_q, tx_y_d;
    logic [NIB_W-1:0] nib_q, nib_d;
    logic [1:0]       btn_q, btn_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             str_q, str_prev_q;
    logic             active_q, active_d;
    logic [PD_W-1:0]  port_data_q, port_data_d;

    logic             step_c;
    logic [ACC_W-1:0] base_x_c, base_y_c;

    // Signed accumulate in 10 bits, then clamp to the 8-bit signed range.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [8:0]       delta);
        logic signed [SUM_W-1:0] sum;
        sum = $signed({{2{acc[ACC_W-1]}}, acc}) + $signed({delta[8], delta});
        if (sum > SAT_MAX) begin
            return 8'h7F;
        end else if (sum < SAT_MIN) begin
            return 8'h80;
        end else begin
            return sum[ACC_W-1:0];
        end
    endfunction

    // Next-state logic: ownership, accumulators, nibble sequencer, timeout, pins.
    always_comb begin
        state_d     = state_q;
        acc_x_d     = acc_x_q;
        acc_y_d     = acc_y_q;
        tx_x_d      = tx_x_q;
        tx_y_d      = tx_y_q;
        nib_d       = nib_q;
        btn_d       = btn_q;
        tmo_d       = tmo_q;
        active_d    = active_q;
        port_data_d = port_data_q;

        // Strobe edge is taken from the registered copy so the pin is sampled once.
        step_c = (str_q != str_prev_q) && active_q;

        // A PH0 step hands the accumulated motion to the snapshot registers.
        base_x_c = (step_c && (state_q == PH0)) ? '0 : acc_x_q;
        base_y_c = (step_c && (state_q == PH0)) ? '0 : acc_y_q;
        acc_x_d  = mouse_strobe ? sat_add(base_x_c, mouse_dx) : base_x_c;
        acc_y_d  = mouse_strobe ? sat_add(base_y_c, mouse_dy) : base_y_c;

        if (mouse_strobe) begin
            btn_d    = mouse_btn;
            active_d = 1'b1;
        end else if (joy_n != JOY_IDLE) begin
            active_d = 1'b0;
        end

        if (!active_d) begin
            state_d = PH0;
            tmo_d   = '0;
            nib_d   = '0;
        end else if (step_c) begin
            tmo_d = TW'(TIMEOUT);
            case (state_q)
                PH0: begin
                    tx_x_d  = acc_x_q;
                    tx_y_d  = acc_y_q;
                    nib_d   = acc_x_q[7:4];
                    state_d = PH1;
                end
                PH1: begin
                    nib_d   = tx_x_q[3:0];
                    state_d = PH2;
                end
                PH2: begin
                    nib_d   = tx_y_q[7:4];
                    state_d = PH3;
                end
                default: begin
                    nib_d   = tx_y_q[3:0];
                    state_d = PH0;
                end
            endcase
        end else if (tmo_q != '0) begin
            tmo_d = tmo_q - TW'(1);
            if (tmo_q == TW'(1)) begin
                state_d = PH0;
            end
        end

        port_data_d = active_q ? {~btn_q[1], ~btn_q[0], nib_q} : joy_n;
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PH0;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            tx_x_q      <= '0;
            tx_y_q      <= '0;
            nib_q       <= '0;
            btn_q       <= '0;
            tmo_q       <= '0;
            str_q       <= 1'b0;
            str_prev_q  <= 1'b0;
            active_q    <= 1'b0;
            port_data_q <= JOY_IDLE;
        end else begin
            state_q     <= state_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            tx_x_q      <= tx_x_d;
            tx_y_q      <= tx_y_d;
            nib_q       <= nib_d;
            btn_q       <= btn_d;
            tmo_q       <= tmo_d;
            str_q       <= msx_str;
            str_prev_q  <= str_q;
            active_q    <= active_d;
            port_data_q <= port_data_d;
        end
    end

    assign port_data    = port_data_q;
    assign mouse_active = active_q;

endmodule

// File: tb/tb_msx_mouse_port.sv
// Scoreboard bench for msx_mouse_port: stimulus pushes timed expectations,
// a negedge monitor pops and compares them against the port pins.
module tb_msx_mouse_port;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       mouse_strobe;
    logic [8:0] mouse_dx;
    logic [8:0] mouse_dy;
    logic [1:0] mouse_btn;
    logic [5:0] joy_n;
    logic       msx_str;
    logic [5:0] port_data;
    logic       mouse_active;

    always #5 clk_sys = ~clk_sys;

    msx_mouse_port #(.TIMEOUT(50), .TW(17)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .mouse_strobe (mouse_strobe),
        .mouse_dx     (mouse_dx),
        .mouse_dy     (mouse_dy),
        .mouse_btn    (mouse_btn),
        .joy_n        (joy_n),
        .msx_str      (msx_str),
        .port_data    (port_data),
        .mouse_active (mouse_active)
    );

    typedef struct packed {
        int unsigned due;
        logic [5:0]  pd;
        logic        act;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Queue an expectation 'lat' rising edges after now, kept sorted by due cycle.
    task automatic expect_out(input int unsigned lat, input logic [5:0] pd,
                              input logic act, input string nm);
        exp_t e;
        int   idx;
        e.due = cyc + lat;
        e.pd  = pd;
        e.act = act;
        idx   = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].due > e.due) begin
                idx = i;
                break;
            end
        end
        exp_q.insert(idx, e);
        name_q.insert(idx, nm);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // One-cycle mouse packet; pins show the new buttons two edges later.
    task automatic send_pkt(input logic [8:0] dx, input logic [8:0] dy,
                            input logic [1:0] btn, input logic [5:0] pd,
                            input string nm);
        mouse_dx     = dx;
        mouse_dy     = dy;
        mouse_btn    = btn;
        mouse_strobe = 1'b1;
        expect_out(2, pd, 1'b1, nm);
        tick(1);
        mouse_strobe = 1'b0;
    endtask

    // Toggle the PPI strobe; the new nibble reaches the pins three edges later.
    task automatic toggle(input logic [5:0] pd, input string nm, input int gap);
        msx_str = ~msx_str;
        expect_out(3, pd, 1'b1, nm);
        tick(gap);
    endtask

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge clk_sys) begin
        exp_t  e;
        string nm;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.due < cyc) begin
                tests++;
                fails++;
                $display("FAIL %s: sample slot %0d missed at cycle %0d", nm, e.due, cyc);
            end else begin
                tests++;
                if (port_data !== e.pd) begin
                    fails++;
                    $display("FAIL %s port_data: got %h expected %h", nm, port_data, e.pd);
                end
                tests++;
                if (mouse_active !== e.act) begin
                    fails++;
                    $display("FAIL %s mouse_active: got %b expected %b", nm, mouse_active, e.act);
                end
            end
        end
    end

    initial begin
        reset_n      = 1'b0;
        mouse_strobe = 1'b0;
        mouse_dx     = '0;
        mouse_dy     = '0;
        mouse_btn    = '0;
        joy_n        = 6'h3F;
        msx_str      = 1'b0;

        tick(2);
        expect_out(0, 6'h3F, 1'b0, "reset_init");
        tick(1);
        reset_n = 1'b1;
        tick(3);

        // Full packet: dx=+0x25, dy=-3, left button
        send_pkt(9'h025, 9'h1FD, 2'b01, 6'h20, "pkt_btn");
        tick(4);
        toggle(6'h22, "pkt_xh", 20);
        toggle(6'h25, "pkt_xl", 20);
        toggle(6'h2F, "pkt_yh", 20);
        toggle(6'h2D, "pkt_yl", 20);
        // Accumulators were cleared by the first edge
        toggle(6'h20, "clr_xh", 8);
        toggle(6'h20, "clr_xl", 8);
        toggle(6'h20, "clr_yh", 8);
        toggle(6'h20, "clr_yl", 8);

        // Saturation, right button; last packet hits both clamp boundaries
        send_pkt(9'h064, 9'h138, 2'b10, 6'h10, "sat1");
        send_pkt(9'h064, 9'h138, 2'b10, 6'h10, "sat2");
        send_pkt(9'h064, 9'h138, 2'b10, 6'h10, "sat3");
        send_pkt(9'h001, 9'h100, 2'b10, 6'h10, "sat_edge");
        tick(4);
        toggle(6'h17, "sat_xh", 6);
        toggle(6'h1F, "sat_xl", 6);
        toggle(6'h18, "sat_yh", 6);
        toggle(6'h10, "sat_yl", 6);

        // Timeout: two edges, new packet, long idle, resync to PH0
        send_pkt(9'h034, 9'h012, 2'b00, 6'h30, "tmo_pkt");
        tick(3);
        toggle(6'h33, "tmo_xh", 6);
        toggle(6'h34, "tmo_xl", 4);
        send_pkt(9'h07B, 9'h1E0, 2'b00, 6'h34, "tmo_pkt2");
        tick(60);
        toggle(6'h37, "tmo_resync", 6);
        toggle(6'h3B, "tmo_xl2", 6);
        toggle(6'h3E, "tmo_yh2", 6);
        toggle(6'h30, "tmo_yl2", 6);

        // Joystick takeover in PH2
        toggle(6'h30, "joy_pre0", 6);
        toggle(6'h30, "joy_pre1", 6);
        joy_n = 6'h3E;
        expect_out(1, 6'h30, 1'b0, "joy_drop");
        expect_out(2, 6'h3E, 1'b0, "joy_pins");
        tick(3);
        joy_n = 6'h2D;
        expect_out(1, 6'h2D, 1'b0, "joy_follow");
        tick(2);
        // Mouse strobe together with joystick activity: strobe wins
        joy_n        = 6'h3E;
        mouse_dx     = 9'h011;
        mouse_dy     = 9'h000;
        mouse_btn    = 2'b11;
        mouse_strobe = 1'b1;
        expect_out(1, 6'h3E, 1'b1, "joy_strobe_wins");
        expect_out(2, 6'h00, 1'b1, "joy_reclaim");
        tick(1);
        mouse_strobe = 1'b0;
        joy_n        = 6'h3F;
        tick(3);
        // Sequencer restarted at PH0
        toggle(6'h01, "joy_ph0", 6);
        toggle(6'h01, "joy_ph1", 6);
        toggle(6'h00, "joy_ph2", 6);
        toggle(6'h00, "joy_ph3", 6);

        // PH0 snapshot in the same cycle as a mouse packet
        send_pkt(9'h00A, 9'h005, 2'b00, 6'h30, "sim_pkt");
        tick(3);
        msx_str = ~msx_str;
        expect_out(3, 6'h30, 1'b1, "sim_snap");
        tick(1);
        mouse_dx     = 9'h003;
        mouse_dy     = 9'h001;
        mouse_btn    = 2'b00;
        mouse_strobe = 1'b1;
        tick(1);
        mouse_strobe = 1'b0;
        tick(5);
        toggle(6'h3A, "sim_txx", 6);
        toggle(6'h30, "sim_tyh", 6);
        toggle(6'h35, "sim_tyl", 6);
        toggle(6'h30, "sim_acc_xh", 6);
        toggle(6'h33, "sim_acc_xl", 6);
        toggle(6'h30, "sim_acc_yh", 6);
        toggle(6'h31, "sim_acc_yl", 6);

        // Reset mid-PH2 with acc_x = 5
        toggle(6'h30, "rst_pre0", 6);
        toggle(6'h30, "rst_pre1", 6);
        send_pkt(9'h005, 9'h000, 2'b00, 6'h30, "rst_pkt");
        tick(3);
        reset_n = 1'b0;
        expect_out(0, 6'h3F, 1'b0, "rst_async");
        tick(2);
        reset_n = 1'b1;
        expect_out(1, 6'h3F, 1'b0, "rst_hold");
        tick(3);
        send_pkt(9'h040, 9'h000, 2'b00, 6'h30, "rst_pkt2");
        tick(3);
        toggle(6'h34, "rst_ph0", 6);
        toggle(6'h30, "rst_no_residue", 6);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
            tick(1);
        end
        while (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL %s: expectation never checked", name_q.pop_front());
            void'(exp_q.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
